hazard_forward_unit: RTL

Parametrised successor to the single-source forwarding unit. It generates two-source operand forwarding selects (EX/MEM and MEM/WB), load-use stall and bubble control, taken-branch flushes, and EX-stage hold for a multi-cycle mul/div unit. It also keeps saturating stall and flush event counters. It sits beside the ID/EX pipeline register and drives the PC enable, IF/ID enable and flush, ID/EX flush, EX/MEM bubble, and the EX operand muxes.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/md_occupancy_fsm.sv | 69 ++++++
 rtl/hazard_forward_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding slice.
//   FWD_*      : encodings of the EX operand-mux select (fA / fB)
//   md_state_t : occupancy state of the multi-cycle mul/div unit
package hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_MEMWB = 2'b01;  // operand from MEM/WB result
  localparam logic [1:0] FWD_EXMEM = 2'b10;  // operand from EX/MEM result

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_occupancy_fsm.sv
// Tracks how long a mul/div op occupies the EX stage.
// A started op holds EX for MD_LATENCY-1 cycles, then raises md_done for one
// cycle in which ex_hold is low so the op can retire.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset (also forces outputs low)
//   start   : the instruction in EX is a mul/div op
//   ex_hold : freeze ID/EX and bubble EX/MEM this cycle
//   md_done : last EX cycle of the mul/div op
module md_occupancy_fsm
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic ex_hold,
  output logic md_done
);

  localparam int CW = $clog2(MD_LATENCY);

  md_state_t       state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ex_hold    = 1'b0;
    md_done    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          // The IDLE cycle itself is the first hold cycle, so BUSY covers
          // MD_LATENCY-2 further hold cycles plus the done cycle.
          ex_hold    = 1'b1;
          state_next = BUSY;
          cnt_next   = CW'(MD_LATENCY - 2);
        end
      end
      BUSY: begin
        if (cnt_reg != '0) begin
          ex_hold  = 1'b1;
          cnt_next = cnt_reg - 1'b1;
        end else begin
          // start is deliberately ignored here: it is still the same op.
          md_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      ex_hold = 1'b0;
      md_done = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding, load-use stall, branch flush and mul/div EX hold for a
// five-stage pipeline, plus saturating stall/flush event counters.
//   IF_ID_Rs1/Rs2, ID_EX_Rs1/Rs2/Rd, ID_EX_MemRead, ID_EX_MulDiv : stage info
//   EX_MEM_Rd/RegWrite, MEM_WB_Rd/RegWrite : producer stages for forwarding
//   branch_taken : taken branch/jump resolved in EX
//   fA, fB       : EX operand selects (see hazard_pkg FWD_*)
//   pc_stall, id_ex_bubble, ex_hold, flush_if_id, flush_id_ex, md_done
//   stall_cnt, flush_cnt : saturating event counters
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] IF_ID_Rs1,
  input  logic [REG_AW-1:0] IF_ID_Rs2,
  input  logic [REG_AW-1:0] ID_EX_Rs1,
  input  logic [REG_AW-1:0] ID_EX_Rs2,
  input  logic [REG_AW-1:0] ID_EX_Rd,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_MulDiv,
  input  logic [REG_AW-1:0] EX_MEM_Rd,
  input  logic              EX_MEM_RegWrite,
  input  logic [REG_AW-1:0] MEM_WB_Rd,
  input  logic              MEM_WB_RegWrite,
  input  logic              branch_taken,
  output logic [1:0]        fA,
  output logic [1:0]        fB,
  output logic              pc_stall,
  output logic              id_ex_bubble,
  output logic              ex_hold,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              md_done,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // ---------------- forwarding ----------------
  logic [REG_AW-1:0] src     [2];
  logic [1:0]        fwd_sel [2];

  assign src[0] = ID_EX_Rs1;
  assign src[1] = ID_EX_Rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic ex_mem_hit;
      logic mem_wb_hit;
      // Writes to x0 are never forwarded: x0 always reads zero.
      assign ex_mem_hit = EX_MEM_RegWrite && (EX_MEM_Rd != '0) && (EX_MEM_Rd == src[gi]);
      assign mem_wb_hit = MEM_WB_RegWrite && (MEM_WB_Rd != '0) && (MEM_WB_Rd == src[gi]);
      // EX/MEM holds the younger result, so it takes precedence.
      assign fwd_sel[gi] = rst        ? FWD_RF    :
                           ex_mem_hit ? FWD_EXMEM :
                           mem_wb_hit ? FWD_MEMWB : FWD_RF;
    end
  endgenerate

  assign fA = fwd_sel[0];
  assign fB = fwd_sel[1];

  // ---------------- hazards ----------------
  logic lu;
  logic flush;

  md_occupancy_fsm #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_fsm (
    .clk     (clk),
    .rst     (rst),
    .start   (ID_EX_MulDiv),
    .ex_hold (ex_hold),
    .md_done (md_done)
  );

  assign lu = !rst && ID_EX_MemRead && (ID_EX_Rd != '0) &&
              ((ID_EX_Rd == IF_ID_Rs1) || (ID_EX_Rd == IF_ID_Rs2));

  // A busy mul/div owns EX, so a branch outcome seen there is not real yet.
  assign flush        = !rst && branch_taken && !ex_hold;
  assign flush_if_id  = flush;
  assign flush_id_ex  = flush;
  // Flush squashes the dependent instruction, so no stall is needed.
  assign pc_stall     = (lu || ex_hold) && !flush;
  // Under ex_hold ID/EX is frozen, so a bubble would overwrite the held op.
  assign id_ex_bubble = lu && !ex_hold && !flush;

  // ---------------- counters ----------------
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (pc_stall && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = rst ? '0 : stall_cnt_reg;
  assign flush_cnt = rst ? '0 : flush_cnt_reg;

endmodule
